// File: rtl/lcrc_if.sv
// lcrc_if: data/CRC bundle for the link CRC generator.
//   in  - 16-bit data word folded into the CRC each non-reset clock (bit 15 first)
//   out - 32-bit running CRC register, straight from flops
// master: the block feeding words and observing the CRC.
// slave:  the CRC generator itself.
interface lcrc_if;
  logic [15:0] in;
  logic [31:0] out;

  modport master (
    output in,
    input  out
  );

  modport slave (
    input  in,
    output out
  );
endinterface

// File: rtl/lcrc.sv
// lcrc: link CRC generator.
// Folds one 16-bit word per clock into a running 32-bit CRC (poly 0x04C11DB7,
// seed 0xFFFFFFFF, MSB-first, no final complement or reflection).
// Ports:
//   clk   - sole clock, rising edge
//   reset - synchronous active-high; loads the seed, has priority over data
//   bus   - lcrc_if slave: bus.in (data word), bus.out (CRC register)
module lcrc (
  input  logic   clk,
  input  logic   reset,
  lcrc_if.slave  bus
);

  localparam logic [31:0] Poly = 32'h04C1_1DB7;
  localparam logic [31:0] Seed = 32'hFFFF_FFFF;

  logic [31:0] crc_q;
  logic [31:0] crc_d;

  // Sixteen serial MSB-first steps unrolled into one XOR network.
  function automatic logic [31:0] crc_fold(input logic [31:0] crc, input logic [15:0] data);
    logic [31:0] c;
    logic        fb;
    c = crc;
    for (int i = 15; i >= 0; i--) begin
      fb = c[31] ^ data[i];
      c  = {c[30:0], 1'b0};
      if (fb) begin
        c = c ^ Poly;
      end
    end
    return c;
  endfunction

  always_comb begin
    crc_d = crc_fold(crc_q, bus.in);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      crc_q <= Seed;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign bus.out = crc_q;

endmodule

// File: tb/tb_lcrc.sv
module tb_lcrc;

  logic clk = 1'b0;
  logic reset;
  int   n_vec = 0;
  int   n_err = 0;
  logic [31:0] model_crc;

  lcrc_if bus ();

  lcrc dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference: closed form via polynomial long division of v * x^32 by P.
  function automatic logic [31:0] model_next(input logic [31:0] c, input logic [15:0] d);
    logic [47:0] r;
    logic [47:0] p;
    r = {c[31:16] ^ d, 32'h0};
    for (int i = 47; i >= 32; i--) begin
      p = {15'h0, 33'h1_04C1_1DB7} << (i - 32);
      if (r[i]) r = r ^ p;
    end
    return {c[15:0], 16'h0} ^ r[31:0];
  endfunction

  // Apply one word (or reset) across one rising edge, update the model, sample #1 later.
  task automatic clock(input logic rst, input logic [15:0] d);
    reset  = rst;
    bus.in = d;
    @(posedge clk);
    #1;
    if (rst) model_crc = 32'hFFFF_FFFF;
    else     model_crc = model_next(model_crc, d);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      clock(1'b1, 16'h0000);
      n_vec++;
      if (bus.out !== 32'hFFFF_FFFF) begin
        n_err++;
        $display("FAIL reset[%0d]: got %08h want ffffffff", i, bus.out);
      end
    end
  endtask

  task automatic test_single_word();
    clock(1'b1, 16'h0000);
    clock(1'b0, 16'h12AB);
    n_vec++;
    if (bus.out !== 32'h6A70_FC0E) begin
      n_err++;
      $display("FAIL single_word: got %08h want 6a70fc0e", bus.out);
    end
  endtask

  task automatic test_seed_cancel();
    clock(1'b1, 16'h0000);
    clock(1'b0, 16'hFFFF);
    n_vec++;
    if (bus.out !== 32'hFFFF_0000) begin
      n_err++;
      $display("FAIL seed_cancel: got %08h want ffff0000", bus.out);
    end
  endtask

  task automatic test_chaining();
    clock(1'b1, 16'h0000);
    clock(1'b0, 16'h12AB);
    n_vec++;
    if (bus.out !== 32'h6A70_FC0E) begin
      n_err++;
      $display("FAIL chain_first: got %08h want 6a70fc0e", bus.out);
    end
    clock(1'b0, 16'hFE87);
    n_vec++;
    if (bus.out !== model_crc) begin
      n_err++;
      $display("FAIL chain_second: got %08h want %08h", bus.out, model_crc);
    end
    clock(1'b0, 16'h0000);
    n_vec++;
    if (bus.out !== model_crc) begin
      n_err++;
      $display("FAIL chain_zero_word: got %08h want %08h", bus.out, model_crc);
    end
  endtask

  task automatic test_reset_midstream();
    logic [31:0] want [3];
    logic        rsts [3];
    want[0] = 32'h6A70_FC0E; want[1] = 32'hFFFF_FFFF; want[2] = 32'h6A70_FC0E;
    rsts[0] = 1'b0;          rsts[1] = 1'b1;          rsts[2] = 1'b0;
    clock(1'b1, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      clock(rsts[i], 16'h12AB);
      n_vec++;
      if (bus.out !== want[i]) begin
        n_err++;
        $display("FAIL midstream[%0d]: got %08h want %08h", i, bus.out, want[i]);
      end
    end
  endtask

  task automatic test_random();
    logic        rst;
    logic [15:0] d;
    clock(1'b1, 16'h0000);
    for (int i = 0; i < 1200; i++) begin
      rst = ($urandom_range(0, 31) == 0);
      d   = 16'($urandom);
      clock(rst, d);
      n_vec++;
      if (bus.out !== model_crc) begin
        n_err++;
        $display("FAIL random[%0d] rst=%0b in=%04h: got %08h want %08h",
                 i, rst, d, bus.out, model_crc);
      end
    end
  endtask

  initial begin
    reset     = 1'b1;
    bus.in    = 16'h0000;
    model_crc = 32'hFFFF_FFFF;
    test_reset();
    test_single_word();
    test_seed_cancel();
    test_chaining();
    test_reset_midstream();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
